// File: rtl/int_top_reg_tx_if.sv
// Handshake and line signals between the message source and the UART transmitter.
// The master side supplies the request and byte; the slave side reports status and drives the line.
interface int_top_reg_tx_if;
    logic       tb_ready;
    logic [7:0] tb_msg;
    logic [7:0] tb_tx_byte;
    logic       tb_tx_ctrl;
    logic       tb_transmit_ready;
    logic       tb_tx_serial;
    logic       tb_blue;

    modport master (
        output tb_ready, tb_msg,
        input  tb_tx_byte, tb_tx_ctrl, tb_transmit_ready, tb_tx_serial, tb_blue
    );

    modport slave (
        input  tb_ready, tb_msg,
        output tb_tx_byte, tb_tx_ctrl, tb_transmit_ready, tb_tx_serial, tb_blue
    );
endinterface

// File: rtl/int_top_reg_tx.sv
// Message register feeding an 8N1 UART transmitter; frames repeat while tb_ready stays high.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module int_top_reg_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic             tb_clk,
    input  logic             tb_nRst,
    int_top_reg_tx_if.slave  bus
);

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_done = (clk_cnt == LAST_CLK);

    // Capture only while the transmitter is idle and no start pulse is pending,
    // so a byte is never loaded twice for the same frame.
    always_ff @(posedge tb_clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (tb_nRst) begin
            bus.tb_tx_byte <= 8'h00;
            bus.tb_tx_ctrl <= 1'b0;
        end else if (bus.tb_ready && bus.tb_transmit_ready && !bus.tb_tx_ctrl) begin
            bus.tb_tx_byte <= bus.tb_msg;
            bus.tb_tx_ctrl <= 1'b1;
        end else begin
            bus.tb_tx_ctrl <= 1'b0;
        end
    end

    always_ff @(posedge tb_clk) begin
        // NOTE: the data shift register is reset too; it is a handful of flops, not a memory array.
        if (tb_nRst) begin
            state                 <= IDLE;
            clk_cnt               <= 16'd0;
            bit_idx               <= 3'd0;
            shift_reg             <= 8'h00;
            bus.tb_tx_serial      <= 1'b1;
            bus.tb_transmit_ready <= 1'b1;
            bus.tb_blue           <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= 16'd0;
                    bit_idx <= 3'd0;
                    if (bus.tb_tx_ctrl) begin
                        shift_reg             <= bus.tb_tx_byte;
`ifdef UART_TX_PARITY_EN
                        parity_bit            <= ^bus.tb_tx_byte;
`endif
                        state                 <= START;
                        bus.tb_tx_serial      <= 1'b0;
                        bus.tb_transmit_ready <= 1'b0;
                        bus.tb_blue           <= 1'b0;
                    end
                end

                START: begin
                    if (bit_done) begin
                        clk_cnt          <= 16'd0;
                        state            <= DATA;
                        bus.tb_tx_serial <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state            <= PARITY;
                            bus.tb_tx_serial <= parity_bit;
`else
                            state            <= STOP;
                            bus.tb_tx_serial <= 1'b1;
`endif
                        end else begin
                            // Shift first, then present the next LSB on the line.
                            bit_idx          <= bit_idx + 3'd1;
                            shift_reg        <= {1'b0, shift_reg[7:1]};
                            bus.tb_tx_serial <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        clk_cnt          <= 16'd0;
                        state            <= STOP;
                        bus.tb_tx_serial <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        clk_cnt               <= 16'd0;
                        state                 <= IDLE;
                        bus.tb_transmit_ready <= 1'b1;
                        bus.tb_blue           <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_top_reg_tx.sv
// Directed bench for int_top_reg_tx at CLKS_PER_BIT=10; frame expectations follow UART_TX_PARITY_EN.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_int_top_reg_tx;

    localparam int CLKS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [NB-1:0] FRAME_AB = {1'b1, 1'b1, 8'hAB, 1'b0};
    localparam logic [NB-1:0] FRAME_6D = {1'b1, 1'b1, 8'h6D, 1'b0};
`else
    localparam int NB = 10;
    localparam logic [NB-1:0] FRAME_AB = {1'b1, 8'hAB, 1'b0};
    localparam logic [NB-1:0] FRAME_6D = {1'b1, 8'h6D, 1'b0};
`endif

    logic tb_clk;
    logic tb_nRst;
    int   vec_cnt;
    int   err_cnt;

    int_top_reg_tx_if bus ();

    int_top_reg_tx #(.CLKS_PER_BIT(CLKS)) dut (
        .tb_clk  (tb_clk),
        .tb_nRst (tb_nRst),
        .bus     (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Samples one whole frame, one bit per CLKS cycles, starting at the current cycle.
    task automatic record_frame(output logic [NB-1:0] bits, output logic stable);
        stable = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bits[b] = bus.tb_tx_serial;
            for (int c = 0; c < CLKS; c++) begin
                if (bus.tb_tx_serial !== bits[b]) stable = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        tb_nRst = 1'b1;
        bus.tb_ready = 1'b0;
        bus.tb_msg = 8'h00;
        tick();
        tick();
        vec_cnt += 5;
        if (bus.tb_tx_serial !== 1'b1) begin err_cnt++; $display("FAIL reset_serial: got %b expected 1", bus.tb_tx_serial); end
        if (bus.tb_transmit_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_tready: got %b expected 1", bus.tb_transmit_ready); end
        if (bus.tb_tx_ctrl !== 1'b0) begin err_cnt++; $display("FAIL reset_ctrl: got %b expected 0", bus.tb_tx_ctrl); end
        if (bus.tb_tx_byte !== 8'h00) begin err_cnt++; $display("FAIL reset_byte: got %h expected 00", bus.tb_tx_byte); end
        if (bus.tb_blue !== 1'b0) begin err_cnt++; $display("FAIL reset_blue: got %b expected 0", bus.tb_blue); end
        tb_nRst = 1'b0;
    endtask

    task automatic test_no_ready();
        logic saw_ctrl, saw_low;
        saw_ctrl = 1'b0;
        saw_low  = 1'b0;
        bus.tb_ready = 1'b0;
        bus.tb_msg = 8'hAB;
        repeat (6500) begin
            tick();
            if (bus.tb_tx_ctrl !== 1'b0) saw_ctrl = 1'b1;
            if (bus.tb_tx_serial !== 1'b1) saw_low = 1'b1;
        end
        vec_cnt += 3;
        if (saw_ctrl !== 1'b0) begin err_cnt++; $display("FAIL idle_ctrl_pulse: got %b expected 0", saw_ctrl); end
        if (saw_low !== 1'b0) begin err_cnt++; $display("FAIL idle_line_low: got %b expected 0", saw_low); end
        if (bus.tb_tx_byte !== 8'h00) begin err_cnt++; $display("FAIL idle_byte: got %h expected 00", bus.tb_tx_byte); end
    endtask

    task automatic test_frame();
        logic [NB-1:0] bits;
        logic stable;
        bus.tb_msg = 8'hAB;
        bus.tb_ready = 1'b1;
        tick();
        vec_cnt += 2;
        if (bus.tb_tx_ctrl !== 1'b1) begin err_cnt++; $display("FAIL cap_ctrl: got %b expected 1", bus.tb_tx_ctrl); end
        if (bus.tb_tx_byte !== 8'hAB) begin err_cnt++; $display("FAIL cap_byte: got %h expected ab", bus.tb_tx_byte); end
        tick();
        vec_cnt += 3;
        if (bus.tb_tx_ctrl !== 1'b0) begin err_cnt++; $display("FAIL ctrl_width: got %b expected 0", bus.tb_tx_ctrl); end
        if (bus.tb_tx_serial !== 1'b0) begin err_cnt++; $display("FAIL start_bit: got %b expected 0", bus.tb_tx_serial); end
        if (bus.tb_transmit_ready !== 1'b0) begin err_cnt++; $display("FAIL busy_tready: got %b expected 0", bus.tb_transmit_ready); end
        record_frame(bits, stable);
        vec_cnt += 5;
        if (bits !== FRAME_AB) begin err_cnt++; $display("FAIL frame_ab: got %b expected %b", bits, FRAME_AB); end
        if (stable !== 1'b1) begin err_cnt++; $display("FAIL bit_width_ab: got %b expected 1", stable); end
        if (bus.tb_blue !== 1'b1) begin err_cnt++; $display("FAIL blue_rise: got %b expected 1", bus.tb_blue); end
        if (bus.tb_transmit_ready !== 1'b1) begin err_cnt++; $display("FAIL done_tready: got %b expected 1", bus.tb_transmit_ready); end
        if (bus.tb_tx_serial !== 1'b1) begin err_cnt++; $display("FAIL gap1_serial: got %b expected 1", bus.tb_tx_serial); end
        tick();
        vec_cnt += 2;
        if (bus.tb_tx_ctrl !== 1'b1) begin err_cnt++; $display("FAIL recap_ctrl: got %b expected 1", bus.tb_tx_ctrl); end
        if (bus.tb_tx_serial !== 1'b1) begin err_cnt++; $display("FAIL gap2_serial: got %b expected 1", bus.tb_tx_serial); end
        tick();
        vec_cnt += 2;
        if (bus.tb_tx_serial !== 1'b0) begin err_cnt++; $display("FAIL restart_bit: got %b expected 0", bus.tb_tx_serial); end
        if (bus.tb_blue !== 1'b0) begin err_cnt++; $display("FAIL blue_fall: got %b expected 0", bus.tb_blue); end
    endtask

    task automatic test_msg_change();
        logic [NB-1:0] bits;
        logic stable;
        bus.tb_msg = 8'h6D;
        vec_cnt += 1;
        if (bus.tb_tx_byte !== 8'hAB) begin err_cnt++; $display("FAIL hold_byte: got %h expected ab", bus.tb_tx_byte); end
        record_frame(bits, stable);
        vec_cnt += 1;
        if (bits !== FRAME_AB) begin err_cnt++; $display("FAIL inflight_frame: got %b expected %b", bits, FRAME_AB); end
        tick();
        vec_cnt += 2;
        if (bus.tb_tx_byte !== 8'h6D) begin err_cnt++; $display("FAIL new_byte: got %h expected 6d", bus.tb_tx_byte); end
        if (bus.tb_tx_ctrl !== 1'b1) begin err_cnt++; $display("FAIL new_ctrl: got %b expected 1", bus.tb_tx_ctrl); end
        tick();
        record_frame(bits, stable);
        vec_cnt += 2;
        if (bits !== FRAME_6D) begin err_cnt++; $display("FAIL frame_6d: got %b expected %b", bits, FRAME_6D); end
        if (stable !== 1'b1) begin err_cnt++; $display("FAIL bit_width_6d: got %b expected 1", stable); end
    endtask

    task automatic test_ready_drop();
        logic [NB-1:0] bits;
        logic stable, saw_low, saw_ctrl, saw_busy;
        tick();
        tick();
        bus.tb_ready = 1'b0;
        record_frame(bits, stable);
        vec_cnt += 1;
        if (bits !== FRAME_6D) begin err_cnt++; $display("FAIL drop_frame: got %b expected %b", bits, FRAME_6D); end
        saw_low = 1'b0;
        saw_ctrl = 1'b0;
        saw_busy = 1'b0;
        repeat (300) begin
            if (bus.tb_tx_serial !== 1'b1) saw_low = 1'b1;
            if (bus.tb_tx_ctrl !== 1'b0) saw_ctrl = 1'b1;
            if (bus.tb_transmit_ready !== 1'b1) saw_busy = 1'b1;
            tick();
        end
        vec_cnt += 3;
        if (saw_low !== 1'b0) begin err_cnt++; $display("FAIL drop_line_low: got %b expected 0", saw_low); end
        if (saw_ctrl !== 1'b0) begin err_cnt++; $display("FAIL drop_ctrl: got %b expected 0", saw_ctrl); end
        if (saw_busy !== 1'b0) begin err_cnt++; $display("FAIL drop_tready: got %b expected 0", saw_busy); end
    endtask

    task automatic test_reset_mid_frame();
        bus.tb_ready = 1'b1;
        tick();
        tick();
        repeat (25) tick();
        vec_cnt += 1;
        if (bus.tb_tx_serial !== 1'b0) begin err_cnt++; $display("FAIL pre_reset_bit: got %b expected 0", bus.tb_tx_serial); end
        tb_nRst = 1'b1;
        tick();
        vec_cnt += 5;
        if (bus.tb_tx_serial !== 1'b1) begin err_cnt++; $display("FAIL abort_serial: got %b expected 1", bus.tb_tx_serial); end
        if (bus.tb_transmit_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_tready: got %b expected 1", bus.tb_transmit_ready); end
        if (bus.tb_tx_ctrl !== 1'b0) begin err_cnt++; $display("FAIL abort_ctrl: got %b expected 0", bus.tb_tx_ctrl); end
        if (bus.tb_tx_byte !== 8'h00) begin err_cnt++; $display("FAIL abort_byte: got %h expected 00", bus.tb_tx_byte); end
        if (bus.tb_blue !== 1'b0) begin err_cnt++; $display("FAIL abort_blue: got %b expected 0", bus.tb_blue); end
        tb_nRst = 1'b0;
        bus.tb_ready = 1'b0;
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        tb_nRst = 1'b1;
        bus.tb_ready = 1'b0;
        bus.tb_msg = 8'h00;
        test_reset();
        test_no_ready();
        test_frame();
        test_msg_change();
        test_ready_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/int_top_reg_tx.md
INT_TOP_REG_TX -- requirements
Module: int_top_reg_tx

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 10, clock cycles per serial bit (legal range 2..65535).
REQ-002 tb_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 tb_nRst  input  1  reset, synchronous, active-high (asserted = 1, sampled on tb_clk rising edge).
REQ-004 tb_ready  input  1  message-valid request; while 1, the block SHALL keep sending frames.
REQ-005 tb_msg  input  8  message byte to transmit.
REQ-006 tb_tx_byte  output  8  message register contents (byte currently loaded for transmission).
REQ-007 tb_tx_ctrl  output  1  one-cycle start pulse from message register to transmitter.
REQ-008 tb_transmit_ready  output  1  transmitter idle and able to accept a byte.
REQ-009 tb_tx_serial  output  1  UART serial line, idle high.
REQ-010 tb_blue  output  1  frame-done indicator.

Function
REQ-011 Message register SHALL capture tb_msg into tb_tx_byte on an edge where tb_ready=1, tb_transmit_ready=1 and tb_tx_ctrl=0, and SHALL assert tb_tx_ctrl for exactly the following cycle.
REQ-012 tb_tx_byte SHALL hold its value between captures; tb_msg changes while a frame is in flight SHALL NOT affect that frame.
REQ-013 Transmitter FSM states: IDLE, START, DATA, STOP (plus PARITY when REQ-021 macro defined); tb_transmit_ready=1 only in IDLE.
REQ-014 IDLE -> START on the edge where tb_tx_ctrl=1; the byte is latched into an internal shift register on that edge.
REQ-015 Line levels: START drives 0, DATA drives bits 0..7 LSB first, STOP drives 1, IDLE drives 1; each state/bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 After STOP, FSM SHALL return to IDLE; with tb_ready still 1, the next capture SHALL occur on the first IDLE edge, giving a 2-cycle idle-high gap between stop bit end and next start bit.
REQ-017 Deasserting tb_ready mid-frame SHALL NOT abort the frame; it completes, then line stays high.
REQ-018 tb_blue SHALL rise on the edge the STOP bit completes and fall on the edge the next START begins.
REQ-019 tb_tx_ctrl asserted when FSM not in IDLE SHALL be ignored (cannot occur by REQ-011 gating).

Reset
REQ-020 While tb_nRst=1 at a rising edge: tb_tx_serial=1, tb_transmit_ready=1, tb_tx_ctrl=0, tb_tx_byte=8'h00, tb_blue=0, FSM=IDLE, bit/cycle counters=0; a frame in progress SHALL be aborted immediately, line high on that edge.

Configuration
REQ-021 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL be inserted between DATA and STOP driving even parity of the 8 data bits for CLKS_PER_BIT cycles (11-bit frame); when undefined, no parity bit (10-bit frame) and no PARITY state logic.

Verification (CLKS_PER_BIT=10, macro undefined unless stated)
REQ-022 Reset: tb_nRst=1 for 2 cycles -> tb_tx_serial=1, tb_transmit_ready=1, tb_tx_ctrl=0, tb_tx_byte=0x00, tb_blue=0.
REQ-023 tb_ready=0, tb_msg=0xAB for 6500 cycles -> no tb_tx_ctrl pulse, tb_tx_serial constant 1, tb_tx_byte=0x00.
REQ-024 tb_ready=1, tb_msg=0xAB -> tb_tx_byte=0xAB, one-cycle tb_tx_ctrl, serial 0,1,1,0,1,0,1,0,1,1 each held 10 cycles, tb_blue=1 after stop; frames repeat while tb_ready=1.
REQ-025 tb_msg changed to 0x6D mid-frame, tb_ready held -> current frame still 0xAB; next frame data bits 1,0,1,1,0,1,1,0; tb_tx_byte=0x6D from that capture.
REQ-026 tb_ready dropped mid-frame -> frame completes, then tb_tx_serial=1 and tb_transmit_ready=1 indefinitely; reset asserted mid-frame -> tb_tx_serial=1 on the reset edge.
REQ-027 Macro defined, tb_msg=0xAB -> parity bit 1 after data bit 7, then stop bit; frame 110 cycles.
